// File: rtl/neuraedge_pm_pkg.sv
// Shared power-management definitions for the neuraedge_npu_50_tops shell:
// P-state encoding, per-state operating-point tables, CSR map and reset thresholds.
package neuraedge_pm_pkg;

    typedef enum logic [1:0] {
        P0 = 2'd0,
        P1 = 2'd1,
        P2 = 2'd2,
        P3 = 2'd3
    } pstate_t;

    localparam logic [15:0] P_FREQ_MHZ [4] = '{16'd400, 16'd600, 16'd800, 16'd1000};
    localparam logic [15:0] P_VOLT_MV  [4] = '{16'd650, 16'd750, 16'd850, 16'd950};
    localparam logic [15:0] P_POWER_MW [4] = '{16'd150, 16'd300, 16'd550, 16'd900};
    localparam logic [7:0]  P_IDLE_E   [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
    localparam logic [7:0]  P_ACTIVE_E [4] = '{8'd2, 8'd4, 8'd7, 8'd11};

    localparam logic [7:0] ADDR_ENERGY_LO    = 8'h60;
    localparam logic [7:0] ADDR_ENERGY_HI    = 8'h64;
    localparam logic [7:0] ADDR_UTIL_HIGH    = 8'hA0;
    localparam logic [7:0] ADDR_UTIL_LOW     = 8'hA4;
    localparam logic [7:0] ADDR_UTIL_OVERRIDE = 8'hB0;
    localparam logic [7:0] ADDR_CUR_FREQ     = 8'hC0;
    localparam logic [7:0] ADDR_CUR_VOLT     = 8'hC4;
    localparam logic [7:0] ADDR_STATUS       = 8'hD0;

    localparam logic [6:0] RST_UTIL_HIGH_PCT = 7'd75;
    localparam logic [6:0] RST_UTIL_LOW_PCT  = 7'd25;

    function automatic pstate_t stepUp(input pstate_t p);
        return (p == P3) ? P3 : pstate_t'(p + 2'd1);
    endfunction

    function automatic pstate_t stepDown(input pstate_t p);
        return (p == P0) ? P0 : pstate_t'(p - 2'd1);
    endfunction

endpackage

// File: rtl/neuraedge_dvfs_ctrl.sv
// Windowed utilization measurement and DVFS P-state selection under thermal
// and power-budget limits; the decision is taken once per window on its last cycle.
module neuraedge_dvfs_ctrl
    import neuraedge_pm_pkg::*;
#(
    parameter int UTIL_WINDOW = 256,
    parameter int TEMP_LIMIT  = 95
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  i_powerMode,
    input  logic [15:0] i_budgetMw,
    input  logic [7:0]  i_tempC,
    input  logic        i_dataValid,
    input  logic [6:0]  i_highPct,
    input  logic [6:0]  i_lowPct,
    input  logic        i_overrideEn,
    input  logic [9:0]  i_overrideVal,
    output pstate_t     o_pstate,
    output logic        o_thermalLimit
);

    localparam int WIN_BITS = $clog2(UTIL_WINDOW);
    localparam logic [WIN_BITS-1:0] WIN_LAST = WIN_BITS'(UTIL_WINDOW - 1);
    localparam logic [7:0] TEMP_LIM8 = 8'(TEMP_LIMIT);

    pstate_t               r_pstate;
    pstate_t               w_nextPstate;
    pstate_t               w_upPstate;
    pstate_t               w_downPstate;
    logic                  r_thermalLimit;
    logic [WIN_BITS-1:0]   r_winCnt;
    logic [WIN_BITS:0]     r_actCnt;
    logic [WIN_BITS:0]     w_actTotal;
    logic [WIN_BITS+7:0]   w_actProd;
    logic [6:0]            w_utilAct;
    logic [6:0]            w_utilOv;
    logic [6:0]            w_util;
    logic                  w_winEnd;
    logic                  w_overTemp;

    // The last cycle's beat belongs to the window, so it is folded in before scaling.
    assign w_winEnd   = (r_winCnt == WIN_LAST);
    assign w_actTotal = r_actCnt + (WIN_BITS+1)'(i_dataValid);
    assign w_actProd  = (WIN_BITS+8)'(w_actTotal) * (WIN_BITS+8)'(100);
    assign w_utilAct  = 7'(w_actProd >> WIN_BITS);
    assign w_utilOv   = 7'(i_overrideVal / 10'd10);
    assign w_util     = i_overrideEn ? w_utilOv : w_utilAct;
    assign w_overTemp = (i_tempC >= TEMP_LIM8);
    assign w_upPstate   = stepUp(r_pstate);
    assign w_downPstate = stepDown(r_pstate);

    always_comb begin
        w_nextPstate = r_pstate;
        if (w_winEnd) begin
            if (i_powerMode == 8'd1) begin
                w_nextPstate = P0;
            end else if (i_powerMode == 8'd2) begin
                w_nextPstate = P3;
            end else if (w_overTemp || (P_POWER_MW[r_pstate] > i_budgetMw)) begin
                w_nextPstate = w_downPstate;
            end else if ((w_util > i_highPct) && (P_POWER_MW[w_upPstate] <= i_budgetMw)) begin
                w_nextPstate = w_upPstate;
            end else if (w_util < i_lowPct) begin
                w_nextPstate = w_downPstate;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pstate       <= P1;
            r_thermalLimit <= 1'b0;
            r_winCnt       <= '0;
            r_actCnt       <= '0;
        end else begin
            r_pstate <= w_nextPstate;
            r_winCnt <= r_winCnt + 1'b1;
            if (w_winEnd) begin
                r_actCnt       <= '0;
                r_thermalLimit <= w_overTemp;
            end else begin
                r_actCnt <= w_actTotal;
            end
        end
    end

    assign o_pstate       = r_pstate;
    assign o_thermalLimit = r_thermalLimit;

endmodule

// File: rtl/neuraedge_npu_50_tops.sv
// NPU power-management shell: CSR decode, 64-bit energy accumulator with high-word
// snapshot, and DVFS control. Optional macro NEURAEDGE_UTIL_OVERRIDE_EN adds the 0xB0 override.
module neuraedge_npu_50_tops
    import neuraedge_pm_pkg::*;
#(
    parameter int UTIL_WINDOW = 256,
    parameter int TEMP_LIMIT  = 95
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   power_mode,
    input  logic [15:0]  system_power_budget_mw,
    input  logic [7:0]   chip_temperature,
    input  logic [15:0]  performance_target_tops,
    input  logic         global_sparsity_enable,
    input  logic [1:0]   global_sparsity_mode,
    input  logic [1:0]   global_precision_mode,
    input  logic [511:0] data_in,
    input  logic         data_valid,
    input  logic         csr_valid,
    input  logic         csr_write,
    input  logic [7:0]   csr_addr,
    input  logic [31:0]  csr_wdata,
    output logic [31:0]  csr_rdata,
    output logic         csr_ready
);

    logic [63:0] r_energy;
    logic [31:0] r_shadow;
    logic [6:0]  r_highPct;
    logic [6:0]  r_lowPct;
    logic        r_ready;
    logic [31:0] r_rdata;
    logic        w_accept;
    logic        w_wrEn;
    logic        w_rdEn;
    logic [6:0]  w_satPct;
    logic [31:0] w_rdMux;
    logic [7:0]  w_energyInc;
    logic        w_overrideEn;
    logic [9:0]  w_overrideVal;
    logic [31:0] w_overrideRd;
    logic        w_thermalLimit;
    pstate_t     w_pstate;
    logic        w_unused;

    assign w_unused = ^{data_in, performance_target_tops};

    assign w_accept = csr_valid & ~r_ready;
    assign w_wrEn   = w_accept & csr_write;
    assign w_rdEn   = w_accept & ~csr_write;
    assign w_satPct = (csr_wdata > 32'd100) ? 7'd100 : csr_wdata[6:0];

`ifdef NEURAEDGE_UTIL_OVERRIDE_EN
    logic        r_overrideEn;
    logic [9:0]  r_overrideVal;

    // Out-of-range writes only disable the override; the stored value is kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrideEn  <= 1'b0;
            r_overrideVal <= '0;
        end else if (w_wrEn && (csr_addr == ADDR_UTIL_OVERRIDE)) begin
            if (csr_wdata <= 32'd1000) begin
                r_overrideEn  <= 1'b1;
                r_overrideVal <= csr_wdata[9:0];
            end else begin
                r_overrideEn <= 1'b0;
            end
        end
    end

    assign w_overrideEn  = r_overrideEn;
    assign w_overrideVal = r_overrideVal;
    assign w_overrideRd  = {r_overrideEn, 21'b0, r_overrideVal};
`else
    assign w_overrideEn  = 1'b0;
    assign w_overrideVal = '0;
    assign w_overrideRd  = '0;
`endif

    neuraedge_dvfs_ctrl #(
        .UTIL_WINDOW (UTIL_WINDOW),
        .TEMP_LIMIT  (TEMP_LIMIT)
    ) u_dvfs (
        .clk            (clk),
        .reset          (reset),
        .i_powerMode    (power_mode),
        .i_budgetMw     (system_power_budget_mw),
        .i_tempC        (chip_temperature),
        .i_dataValid    (data_valid),
        .i_highPct      (r_highPct),
        .i_lowPct       (r_lowPct),
        .i_overrideEn   (w_overrideEn),
        .i_overrideVal  (w_overrideVal),
        .o_pstate       (w_pstate),
        .o_thermalLimit (w_thermalLimit)
    );

    always_comb begin
        w_rdMux = '0;
        case (csr_addr)
            ADDR_ENERGY_LO:     w_rdMux = r_energy[31:0];
            ADDR_ENERGY_HI:     w_rdMux = r_shadow;
            ADDR_UTIL_HIGH:     w_rdMux = {25'b0, r_highPct};
            ADDR_UTIL_LOW:      w_rdMux = {25'b0, r_lowPct};
            ADDR_UTIL_OVERRIDE: w_rdMux = w_overrideRd;
            ADDR_CUR_FREQ:      w_rdMux = {16'b0, P_FREQ_MHZ[w_pstate]};
            ADDR_CUR_VOLT:      w_rdMux = {16'b0, P_VOLT_MV[w_pstate]};
            ADDR_STATUS:        w_rdMux = {23'b0, global_precision_mode, global_sparsity_mode,
                                           global_sparsity_enable, w_thermalLimit,
                                           w_overrideEn, w_pstate};
            default:            w_rdMux = '0;
        endcase
    end

    assign w_energyInc = P_IDLE_E[w_pstate] + (data_valid ? P_ACTIVE_E[w_pstate] : 8'd0);

    // Reading the low word freezes the high word so a LO-then-HI pair is coherent.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_energy  <= '0;
            r_shadow  <= '0;
            r_highPct <= RST_UTIL_HIGH_PCT;
            r_lowPct  <= RST_UTIL_LOW_PCT;
            r_ready   <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_energy <= r_energy + 64'(w_energyInc);
            r_ready  <= w_accept;
            if (w_rdEn) begin
                r_rdata <= w_rdMux;
                if (csr_addr == ADDR_ENERGY_LO) begin
                    r_shadow <= r_energy[63:32];
                end
            end
            if (w_wrEn && (csr_addr == ADDR_UTIL_HIGH)) begin
                r_highPct <= w_satPct;
            end
            if (w_wrEn && (csr_addr == ADDR_UTIL_LOW)) begin
                r_lowPct <= w_satPct;
            end
        end
    end

    assign csr_ready = r_ready;
    assign csr_rdata = r_rdata;

endmodule

// File: tb/tb_neuraedge_npu_50_tops.sv
// Randomized scoreboard bench for neuraedge_npu_50_tops: a cycle-level reference
// model predicts every CSR response, and a monitor compares each one as it appears.
module tb_neuraedge_npu_50_tops;

    localparam int WIN = 256;
    localparam int TLIM = 95;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   power_mode;
    logic [15:0]  system_power_budget_mw;
    logic [7:0]   chip_temperature;
    logic [15:0]  performance_target_tops;
    logic         global_sparsity_enable;
    logic [1:0]   global_sparsity_mode;
    logic [1:0]   global_precision_mode;
    logic [511:0] data_in;
    logic         data_valid;
    logic         csr_valid;
    logic         csr_write;
    logic [7:0]   csr_addr;
    logic [31:0]  csr_wdata;
    logic [31:0]  csr_rdata;
    logic         csr_ready;

    always #5 clk = ~clk;

    neuraedge_npu_50_tops dut (
        .clk                     (clk),
        .reset                   (reset),
        .power_mode              (power_mode),
        .system_power_budget_mw  (system_power_budget_mw),
        .chip_temperature        (chip_temperature),
        .performance_target_tops (performance_target_tops),
        .global_sparsity_enable  (global_sparsity_enable),
        .global_sparsity_mode    (global_sparsity_mode),
        .global_precision_mode   (global_precision_mode),
        .data_in                 (data_in),
        .data_valid              (data_valid),
        .csr_valid               (csr_valid),
        .csr_write               (csr_write),
        .csr_addr                (csr_addr),
        .csr_wdata               (csr_wdata),
        .csr_rdata               (csr_rdata),
        .csr_ready               (csr_ready)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] exp;
    } txn_t;

    txn_t sbQ[$];
    txn_t sbT;
    txn_t monT;
    int   total = 0;
    int   bad = 0;
    int   dvPct = 0;

    int freqTab[4]  = '{400, 600, 800, 1000};
    int voltTab[4]  = '{650, 750, 850, 950};
    int powerTab[4] = '{150, 300, 550, 900};
    int idleTab[4]  = '{1, 2, 3, 4};
    int actTab[4]   = '{2, 4, 7, 11};

    logic [63:0] mEnergy;
    logic [31:0] mShadow;
    logic [31:0] mRdata;
    int          mHigh, mLow, mOvVal, mP, mWin, mAct, mBeats, mUtil;
    bit          mOvEn, mTherm, mReady, pendWr;
    logic [7:0]  pendAddr;
    logic [31:0] pendData;

    function automatic logic [31:0] modelRead(input logic [7:0] a);
        case (a)
            8'h60: return mEnergy[31:0];
            8'h64: return mShadow;
            8'hA0: return 32'(mHigh);
            8'hA4: return 32'(mLow);
`ifdef NEURAEDGE_UTIL_OVERRIDE_EN
            8'hB0: return {mOvEn, 21'b0, 10'(mOvVal)};
`endif
            8'hC0: return 32'(freqTab[mP]);
            8'hC4: return 32'(voltTab[mP]);
            8'hD0: return {23'b0, global_precision_mode, global_sparsity_mode,
                           global_sparsity_enable, mTherm, mOvEn, 2'(mP)};
            default: return 32'd0;
        endcase
    endfunction

    // Reference model: pre-edge state answers reads, then the edge's updates apply.
    always @(posedge clk) begin
        if (reset) begin
            mEnergy = '0; mShadow = '0; mRdata = '0;
            mHigh = 75; mLow = 25; mOvVal = 0; mOvEn = 0;
            mP = 1; mTherm = 0; mReady = 0; mWin = 0; mAct = 0;
        end else begin
            pendWr = 0;
            if (csr_valid && !mReady) begin
                if (csr_write) begin
                    pendWr = 1; pendAddr = csr_addr; pendData = csr_wdata;
                end else begin
                    mRdata = modelRead(csr_addr);
                    if (csr_addr == 8'h60) mShadow = mEnergy[63:32];
                end
                sbT.addr = csr_addr;
                sbT.exp  = mRdata;
                sbQ.push_back(sbT);
                mReady = 1;
            end else begin
                mReady = 0;
            end
            mEnergy = mEnergy + 64'(idleTab[mP] + (data_valid ? actTab[mP] : 0));
            mBeats = mAct + (data_valid ? 1 : 0);
            if (mWin == WIN - 1) begin
                mUtil = mOvEn ? (mOvVal / 10) : (mBeats * 100) / WIN;
                mTherm = (int'(chip_temperature) >= TLIM);
                if (power_mode == 8'd1) mP = 0;
                else if (power_mode == 8'd2) mP = 3;
                else if (mTherm || powerTab[mP] > int'(system_power_budget_mw)) mP = (mP > 0) ? mP - 1 : 0;
                else if (mUtil > mHigh && powerTab[(mP < 3) ? mP + 1 : 3] <= int'(system_power_budget_mw))
                    mP = (mP < 3) ? mP + 1 : 3;
                else if (mUtil < mLow) mP = (mP > 0) ? mP - 1 : 0;
                mAct = 0;
            end else begin
                mAct = mBeats;
            end
            mWin = (mWin + 1) % WIN;
            if (pendWr) begin
                if (pendAddr == 8'hA0) mHigh = (pendData > 100) ? 100 : int'(pendData);
                if (pendAddr == 8'hA4) mLow  = (pendData > 100) ? 100 : int'(pendData);
`ifdef NEURAEDGE_UTIL_OVERRIDE_EN
                if (pendAddr == 8'hB0) begin
                    if (pendData <= 1000) begin mOvVal = int'(pendData); mOvEn = 1; end
                    else mOvEn = 0;
                end
`endif
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every response the DUT presents must match the oldest prediction.
    always @(negedge clk) begin
        if (!reset && csr_ready) begin
            if (sbQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL csr_unexpected_ready actual=rdata 0x%08h required=no response", csr_rdata);
            end else begin
                monT = sbQ.pop_front();
                checkOutput($sformatf("csr_rdata@0x%02h", monT.addr), csr_rdata, monT.exp);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        data_valid = ($urandom_range(0, 99) < dvPct);
        data_in = {16{$urandom}};
    endtask

    task automatic runCycles(input int n);
        repeat (n) tick();
    endtask

    task automatic applyStimulus(input bit wr, input logic [7:0] a, input logic [31:0] d);
        tick();
        csr_valid = 1'b1; csr_write = wr; csr_addr = a; csr_wdata = d;
        tick();
        csr_valid = 1'b0; csr_write = 1'($urandom); csr_addr = 8'($urandom); csr_wdata = $urandom;
        tick();
    endtask

    task automatic readOpPoint();
        applyStimulus(0, 8'hC0, 0);
        applyStimulus(0, 8'hC4, 0);
        applyStimulus(0, 8'hD0, 0);
        applyStimulus(0, 8'h60, 0);
        applyStimulus(0, 8'h64, 0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        runCycles(4);
        checkOutput("reset_csr_ready", {31'b0, csr_ready}, 32'd0);
        checkOutput("reset_csr_rdata", csr_rdata, 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        power_mode = 8'd0;
        system_power_budget_mw = 16'd1000;
        chip_temperature = 8'd40;
        performance_target_tops = 16'd50;
        global_sparsity_enable = 1'b1;
        global_sparsity_mode = 2'd2;
        global_precision_mode = 2'd1;
        data_in = '0;
        data_valid = 1'b0;
        csr_valid = 1'b0;
        csr_write = 1'b0;
        csr_addr = '0;
        csr_wdata = '0;

        doReset();
        foreach (freqTab[i]) ;
        applyStimulus(0, 8'hC0, 0);
        applyStimulus(0, 8'hC4, 0);
        applyStimulus(0, 8'hA0, 0);
        applyStimulus(0, 8'hA4, 0);
        applyStimulus(0, 8'h60, 0);
        applyStimulus(0, 8'h64, 0);
        applyStimulus(0, 8'hD0, 0);
        applyStimulus(0, 8'hB0, 0);
        applyStimulus(0, 8'h12, 0);

        $display("[TB] idle run, expecting walk down to P0");
        dvPct = 0;
        repeat (8) begin
            runCycles(250);
            applyStimulus(0, 8'h60, 0);
            applyStimulus(0, 8'h64, 0);
        end
        readOpPoint();

        $display("[TB] thresholds, saturation and read-only writes");
        applyStimulus(1, 8'hA0, 32'd300);
        applyStimulus(0, 8'hA0, 0);
        applyStimulus(1, 8'hA4, 32'd101);
        applyStimulus(0, 8'hA4, 0);
        applyStimulus(1, 8'hA0, 32'd80);
        applyStimulus(1, 8'hA4, 32'd50);
        applyStimulus(1, 8'hC0, 32'd5);
        applyStimulus(1, 8'h60, 32'hFFFF_FFFF);
        applyStimulus(0, 8'hC0, 0);
        applyStimulus(1, 8'hB0, 32'd900);
        applyStimulus(0, 8'hB0, 0);

        $display("[TB] high activity, expecting step up to P3");
        dvPct = 97;
        repeat (5) begin runCycles(WIN); readOpPoint(); end

        $display("[TB] low activity, expecting step down");
        dvPct = 20;
        repeat (4) begin runCycles(WIN); readOpPoint(); end

        $display("[TB] thermal limit with high activity");
        dvPct = 97;
        repeat (2) begin runCycles(WIN); readOpPoint(); end
        chip_temperature = 8'd100;
        repeat (4) begin runCycles(WIN); readOpPoint(); end
        chip_temperature = 8'd95;
        runCycles(WIN); readOpPoint();
        chip_temperature = 8'd94;
        runCycles(WIN); readOpPoint();

        $display("[TB] power budget 500 caps at P1");
        system_power_budget_mw = 16'd500;
        repeat (4) begin runCycles(WIN); readOpPoint(); end
        system_power_budget_mw = 16'd1000;

        $display("[TB] pinned modes");
        power_mode = 8'd2;
        runCycles(WIN); readOpPoint();
        power_mode = 8'd1;
        runCycles(WIN); readOpPoint();
        power_mode = 8'd0;

        $display("[TB] randomized traffic");
        for (int k = 0; k < 40; k++) begin
            int sel;
            logic [7:0] addrPool[10];
            addrPool = '{8'h60, 8'h64, 8'hA0, 8'hA4, 8'hB0, 8'hC0, 8'hC4, 8'hD0, 8'h68, 8'hFF};
            sel = $urandom_range(0, 9);
            dvPct = $urandom_range(0, 100);
            case ($urandom_range(0, 4))
                0: power_mode = 8'd1;
                1: power_mode = 8'd2;
                2: power_mode = 8'd7;
                default: power_mode = 8'd0;
            endcase
            system_power_budget_mw = 16'($urandom_range(100, 1200));
            chip_temperature = 8'($urandom_range(60, 110));
            global_sparsity_enable = 1'($urandom);
            global_sparsity_mode = 2'($urandom);
            global_precision_mode = 2'($urandom);
            if ($urandom_range(0, 3) == 0)
                applyStimulus(1, addrPool[sel], 32'($urandom_range(0, 1200)));
            else
                applyStimulus(0, addrPool[sel], 0);
            runCycles($urandom_range(0, 150));
        end
        power_mode = 8'd0;
        readOpPoint();

        $display("[TB] reset mid-operation");
        doReset();
        applyStimulus(0, 8'hA0, 0);
        applyStimulus(0, 8'hA4, 0);
        readOpPoint();

        runCycles(5);
        total++;
        if (sbQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain actual=%0d pending required=0 pending", sbQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
